// File: rtl/alu_share_arbiter_if.sv
// Request/response handshake bundle between two requesters, one consumer and alu_share_arbiter.
// The master side drives requests and response acceptance; the slave side is the arbiter.
interface alu_share_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [24:0] req0_data;
    logic [24:0] req1_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_id;

    modport master (
        output req_valid, req0_data, req1_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req0_data, req1_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational 8-bit ALU between two requesters, one op in flight.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt0/1).
module alu_share_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    alu_share_arbiter_if.slave bus,
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    output logic [1:0]         alu_s1,
    output logic [2:0]         alu_s2,
    output logic [3:0]         alu_s3,
    input  logic [7:0]         alu_o,
    output logic               busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]        grant_cnt0,
    output logic [15:0]        grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(ALU_LAT - 1);

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [24:0] op_q, op_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        sel;
    logic        hs;

    // prio_q names the requester that wins when both are valid.
    always_comb begin
        sel = bus.req_valid[1];
        if (bus.req_valid == 2'b11) sel = prio_q;
        bus.req_ready = 2'b00;
        if (state_q == IDLE && !rst && bus.req_valid != 2'b00)
            bus.req_ready = sel ? 2'b10 : 2'b01;
    end

    assign hs = |bus.req_ready;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d  = ISSUE;
                    op_d     = sel ? bus.req1_data : bus.req0_data;
                    rsp_id_d = sel;
                    prio_d   = ~sel;
                    cnt_d    = 4'd0;
                end
            end
            ISSUE: begin
                if (cnt_q == CNT_LAST) begin
                    rsp_data_d  = alu_o;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            cnt_q       <= 4'd0;
            op_q        <= 25'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Op packing is {s3, s2, s1, b, a}; the registers persist after completion.
    assign alu_a  = op_q[7:0];
    assign alu_b  = op_q[15:8];
    assign alu_s1 = op_q[17:16];
    assign alu_s2 = op_q[20:18];
    assign alu_s3 = op_q[24:21];

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state_q != IDLE);

`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt0_q, grant_cnt0_d;
    logic [15:0] grant_cnt1_q, grant_cnt1_d;

    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (hs && !sel && grant_cnt0_q != 16'hFFFF) grant_cnt0_d = grant_cnt0_q + 16'd1;
        if (hs &&  sel && grant_cnt1_q != 16'hFFFF) grant_cnt1_d = grant_cnt1_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0_q <= 16'd0;
            grant_cnt1_q <= 16'd0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: two instances (ALU_LAT=1 and ALU_LAT=3) share one stimulus stream
// and are each compared every cycle against a time-based transaction model, plus literal pins.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [24:0] req0_data;
    logic [24:0] req1_data;
    logic        rsp_ready;
    bit          log_en = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       busy;
        logic [1:0] ready;
        logic       rv;
        logic       rid;
        logic [7:0] rdata;
        logic [3:0] s3;
        logic [2:0] s2;
        logic [1:0] s1;
        logic [7:0] b;
        logic [7:0] a;
    } obs_t;

    obs_t       obs [2];
    int         grants [2][$];
    logic [8:0] rsps [2][$];

    always #5 clk = ~clk;

    function automatic logic [24:0] pack(logic [7:0] a, logic [7:0] b, logic [1:0] s1,
                                         logic [2:0] s2, logic [3:0] s3);
        return {s3, s2, s1, b, a};
    endfunction

    // ALU stub: add, subtract, AND for the documented selects; XOR for anything else.
    function automatic logic [7:0] alu_ref(logic [24:0] op);
        logic [7:0] a, b;
        a = op[7:0];
        b = op[15:8];
        if (op[17:16] == 2'd0 && op[20:18] == 3'd0) return a + b;
        if (op[17:16] == 2'd0 && op[20:18] == 3'd1) return a - b;
        if (op[17:16] == 2'd1 && op[24:21] == 4'd0) return a & b;
        return a ^ b;
    endfunction

    function automatic bit pick(logic [1:0] v, bit p);
        return (v == 2'b11) ? p : v[1];
    endfunction

    task automatic chk(int k, string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %0h expected %0h at %0t", k, nm, act, exp, $time);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int LAT = (k == 0) ? 1 : 3;

        alu_share_arbiter_if ifc();
        logic [7:0] alu_a, alu_b, alu_o;
        logic [1:0] alu_s1;
        logic [2:0] alu_s2;
        logic [3:0] alu_s3;
        logic       busy;
`ifdef ALU_ARB_STATS_EN
        logic [15:0] gc0, gc1;
`endif

        assign ifc.req_valid = req_valid;
        assign ifc.req0_data = req0_data;
        assign ifc.req1_data = req1_data;
        assign ifc.rsp_ready = rsp_ready;
        assign alu_o = alu_ref({alu_s3, alu_s2, alu_s1, alu_b, alu_a});
        assign obs[k] = {busy, ifc.req_ready, ifc.rsp_valid, ifc.rsp_id, ifc.rsp_data,
                         alu_s3, alu_s2, alu_s1, alu_b, alu_a};

        alu_share_arbiter #(.ALU_LAT(LAT)) dut (
            .clk(clk),
            .rst(rst),
            .bus(ifc),
            .alu_a(alu_a),
            .alu_b(alu_b),
            .alu_s1(alu_s1),
            .alu_s2(alu_s2),
            .alu_s3(alu_s3),
            .alu_o(alu_o),
            .busy(busy)
`ifdef ALU_ARB_STATS_EN
            ,
            .grant_cnt0(gc0),
            .grant_cnt1(gc1)
`endif
        );

        // Model: an accepted op is owned for LAT+1 cycles, then its result is offered until taken.
        int          m_cyc = 0;
        int          m_rsp_at = 0;
        bit          m_started = 1'b0;
        bit          m_busy = 1'b0;
        bit          m_prio = 1'b0;
        bit          m_id = 1'b0;
        logic [24:0] m_op = '0;
        logic [7:0]  m_rdata = '0;
        int          m_cnt0 = 0;
        int          m_cnt1 = 0;

        always @(posedge clk) begin
            m_started <= 1'b1;
            m_cyc     <= m_cyc + 1;
            if (rst) begin
                m_busy <= 1'b0;
                m_prio <= 1'b0;
                m_id   <= 1'b0;
                m_op   <= '0;
                m_cnt0 <= 0;
                m_cnt1 <= 0;
            end else if (!m_busy) begin
                if (req_valid != 2'b00) begin
                    m_busy   <= 1'b1;
                    m_rsp_at <= m_cyc + LAT + 1;
                    m_id     <= pick(req_valid, m_prio);
                    m_prio   <= !pick(req_valid, m_prio);
                    m_op     <= pick(req_valid, m_prio) ? req1_data : req0_data;
                    m_rdata  <= alu_ref(pick(req_valid, m_prio) ? req1_data : req0_data);
                    if (!pick(req_valid, m_prio) && m_cnt0 < 65535) m_cnt0 <= m_cnt0 + 1;
                    if ( pick(req_valid, m_prio) && m_cnt1 < 65535) m_cnt1 <= m_cnt1 + 1;
                end
            end else if (m_cyc >= m_rsp_at && rsp_ready) begin
                m_busy <= 1'b0;
            end
        end

        always @(negedge clk) begin
            if (m_started) begin
                chk(k, "req_ready", ifc.req_ready,
                    (!rst && !m_busy && req_valid != 2'b00) ?
                        (pick(req_valid, m_prio) ? 2'b10 : 2'b01) : 2'b00);
                chk(k, "busy", busy, m_busy);
                chk(k, "rsp_valid", ifc.rsp_valid, m_busy && (m_cyc >= m_rsp_at));
                chk(k, "alu_ops", {alu_s3, alu_s2, alu_s1, alu_b, alu_a}, m_op);
                if (m_busy && m_cyc >= m_rsp_at) begin
                    chk(k, "rsp_data", ifc.rsp_data, m_rdata);
                    chk(k, "rsp_id", ifc.rsp_id, m_id);
                end
`ifdef ALU_ARB_STATS_EN
                chk(k, "grant_cnt0", gc0, m_cnt0);
                chk(k, "grant_cnt1", gc1, m_cnt1);
`endif
            end
            if (log_en && ifc.req_ready != 2'b00) grants[k].push_back(int'(ifc.req_ready[1]));
            if (log_en && ifc.rsp_valid && ifc.rsp_ready) rsps[k].push_back({ifc.rsp_id, ifc.rsp_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((obs[0].busy || obs[1].busy) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk(0, "idle_timeout", 32'(t < 50), 1);
    endtask

    // Issues one op with rsp_ready high; result due 2 cycles (LAT=1) and 4 cycles (LAT=3) later.
    task automatic run_single(bit id, logic [24:0] op, logic [7:0] exp);
        tick();
        req_valid = id ? 2'b10 : 2'b01;
        if (id) req1_data = op;
        else    req0_data = op;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk(k, "single_ready", obs[k].ready, id ? 2'b10 : 2'b01);
        tick();
        req_valid = 2'b00;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            chk(0, "single_rv", obs[0].rv, 32'(n == 2));
            chk(1, "single_rv", obs[1].rv, 32'(n == 4));
            if (n == 1) begin
                chk(0, "single_alu_a", obs[0].a, op[7:0]);
                chk(0, "single_alu_b", obs[0].b, op[15:8]);
            end
            if (n == 2) begin
                chk(0, "single_data", obs[0].rdata, exp);
                chk(0, "single_id", obs[0].rid, id);
            end
            if (n == 4) begin
                chk(1, "single_data", obs[1].rdata, exp);
                chk(1, "single_id", obs[1].rid, id);
            end
        end
    endtask

    initial begin
        logic [1:0] taken;

        rst       = 1'b1;
        req_valid = 2'b11;
        req0_data = pack(8'h07, 8'h04, 2'd0, 3'd0, 4'd0);
        req1_data = pack(8'h07, 8'h04, 2'd0, 3'd1, 4'd0);
        rsp_ready = 1'b1;

        // Reset held two cycles with both requests pending.
        tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk(k, "rst_ready", obs[k].ready, 2'b00);
            chk(k, "rst_rv", obs[k].rv, 0);
            chk(k, "rst_busy", obs[k].busy, 0);
            chk(k, "rst_alu", {obs[k].s3, obs[k].s2, obs[k].s1, obs[k].b, obs[k].a}, 0);
        end

        // Contention from reset: grant order 0,1,0,1.
        tick();
        rst    = 1'b0;
        log_en = 1'b1;
        for (int t = 0; t < 80 && grants[1].size() < 4; t++) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk(k, "rr_count", 32'(grants[k].size() >= 4), 1);
            if (grants[k].size() >= 4)
                for (int i = 0; i < 4; i++) chk(k, "rr_order", grants[k][i], i % 2);
            chk(k, "rr_rsp_count", 32'(rsps[k].size() >= 2), 1);
            if (rsps[k].size() >= 2) begin
                chk(k, "rr_rsp0", rsps[k][0], {1'b0, 8'h0B});
                chk(k, "rr_rsp1", rsps[k][1], {1'b1, 8'h03});
            end
        end
        tick();
        req_valid = 2'b00;
        log_en    = 1'b0;
        wait_idle();

        run_single(1'b0, pack(8'h07, 8'h04, 2'd0, 3'd0, 4'd0), 8'h0B);
        run_single(1'b0, pack(8'h07, 8'h04, 2'd1, 3'd0, 4'd0), 8'h04);

        // Backpressure: response held while rsp_ready is low, req1 waits meanwhile.
        tick();
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        req0_data = pack(8'h07, 8'h04, 2'd0, 3'd0, 4'd0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk(k, "bp_ready0", obs[k].ready, 2'b01);
        tick();
        req_valid = 2'b10;
        req1_data = pack(8'h22, 8'h11, 2'd0, 3'd0, 4'd0);
        @(negedge clk);
        chk(0, "bp_rv_early", obs[0].rv, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk(0, "bp_rv", obs[0].rv, 1);
            chk(0, "bp_data", obs[0].rdata, 8'h0B);
            chk(0, "bp_id", obs[0].rid, 0);
            for (int k = 0; k < 2; k++) chk(k, "bp_ready", obs[k].ready, 2'b00);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk(0, "bp_rv_accept", obs[0].rv, 1);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk(k, "bp_rv_drop", obs[k].rv, 0);
            chk(k, "bp_regrant", obs[k].ready, 2'b10);
        end
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk(k, "bp_busy_again", obs[k].busy, 1);
        wait_idle();

        // Reset while the op is in ISSUE: no response may follow.
        tick();
        req_valid = 2'b01;
        req0_data = pack(8'h31, 8'h02, 2'd0, 3'd0, 4'd0);
        tick();
        req_valid = 2'b00;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk(k, "midrst_busy", obs[k].busy, 0);
            chk(k, "midrst_alu", {obs[k].s3, obs[k].s2, obs[k].s1, obs[k].b, obs[k].a}, 0);
        end
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 2; k++) chk(k, "midrst_no_rsp", obs[k].rv, 0);
            @(negedge clk);
        end

`ifdef ALU_ARB_STATS_EN
        for (int i = 0; i < 3; i++) run_single(1'b0, pack(8'h10, 8'h05, 2'd0, 3'd0, 4'd0), 8'h15);
        for (int i = 0; i < 2; i++) run_single(1'b1, pack(8'h10, 8'h05, 2'd0, 3'd1, 4'd0), 8'h0B);
        chk(0, "stats_cnt0", g[0].gc0, 3);
        chk(0, "stats_cnt1", g[0].gc1, 2);
        chk(1, "stats_cnt0", g[1].gc0, 3);
        chk(1, "stats_cnt1", g[1].gc1, 2);
`endif

        // Random traffic; requesters hold until the LAT=1 instance accepts, the model covers both.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            taken = obs[0].ready & req_valid;
            tick();
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || taken[i]) begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    if (i == 0)
                        req0_data = pack(8'($urandom), 8'($urandom), 2'($urandom_range(0, 1)),
                                         3'($urandom_range(0, 1)),
                                         ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0);
                    else
                        req1_data = pack(8'($urandom), 8'($urandom), 2'($urandom_range(0, 1)),
                                         3'($urandom_range(0, 1)),
                                         ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0);
                end
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 299) == 0);
        end
        tick();
        rst       = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
